// File: rtl/npu_conv_seq.sv
// Convolution sequencer: walks a 3x3 window over a runtime-sized feature map,
// issues the per-position channel steps and counts returning outputs until done.
module npu_conv_seq #(
    parameter int WIDTH_B   = 7,
    parameter int HEIGHT_B  = 3,
    parameter int STEP_B    = 3,
    parameter int OUT_CH    = 8,
    parameter int DRAIN_MAX = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH_B-1:0]    cfg_last_w,
    input  logic [HEIGHT_B-1:0]   cfg_last_h,
    input  logic                  cfg_stride2,
    input  logic [STEP_B-1:0]     cfg_steps,
    input  logic                  cfg_relu,
    input  logic                  cfg_mp,
    input  logic                  hold,
    input  logic [OUT_CH-1:0]     out_en,
    output logic [WIDTH_B*9-1:0]  readi_w,
    output logic [HEIGHT_B*9-1:0] readi_h,
    output logic [8:0]            en_read,
    output logic                  en_bias,
    output logic [STEP_B-1:0]     step,
    output logic                  en_pe,
    output logic [STEP_B-1:0]     step_p,
    output logic [STEP_B-1:0]     bound_level,
    output logic                  en_relu,
    output logic                  en_mp,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CNT_B = WIDTH_B + HEIGHT_B;
    localparam int DRN_B = $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH_B-1:0]    last_w_q, last_w_d;
    logic [HEIGHT_B-1:0]   last_h_q, last_h_d;
    logic                  stride2_q, stride2_d;
    logic [STEP_B-1:0]     steps_q, steps_d;
    logic                  relu_q, relu_d;
    logic                  mp_q, mp_d;
    logic [WIDTH_B-1:0]    ox_q, ox_d;
    logic [HEIGHT_B-1:0]   oy_q, oy_d;
    logic [STEP_B-1:0]     s_q, s_d;
    logic [CNT_B-1:0]      cnt_q, cnt_d;
    logic [DRN_B-1:0]      drn_q, drn_d;
    logic                  err_q, err_d;

    logic [WIDTH_B*9-1:0]  rw_q, rw_d;
    logic [HEIGHT_B*9-1:0] rh_q, rh_d;
    logic [8:0]            ren_q, ren_d;
    logic                  bias_q, bias_d;
    logic [STEP_B-1:0]     stp_q, stp_d;
    logic                  pe_q, pe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [WIDTH_B-1:0]    span_w_s, last_ox_s, base_w_s;
    logic [HEIGHT_B-1:0]   span_h_s, last_oy_s, base_h_s;
    logic [CNT_B-1:0]      n_out_s;
    logic                  cfg_bad_s, beat_s, pos_end_s, row_end_s, last_beat_s;
    logic                  cnt_full_s, drain_to_s;

    // Window geometry derived from the latched config plus loop-end flags.
    always_comb begin
        span_w_s    = last_w_q - WIDTH_B'(2);
        span_h_s    = last_h_q - HEIGHT_B'(2);
        last_ox_s   = stride2_q ? {1'b0, span_w_s[WIDTH_B-1:1]} : span_w_s;
        last_oy_s   = stride2_q ? {1'b0, span_h_s[HEIGHT_B-1:1]} : span_h_s;
        base_w_s    = stride2_q ? {ox_q[WIDTH_B-2:0], 1'b0} : ox_q;
        base_h_s    = stride2_q ? {oy_q[HEIGHT_B-2:0], 1'b0} : oy_q;
        n_out_s     = (CNT_B'(last_ox_s) + CNT_B'(1)) * (CNT_B'(last_oy_s) + CNT_B'(1));
        cfg_bad_s   = (last_w_q < WIDTH_B'(2)) || (last_h_q < HEIGHT_B'(2));
        beat_s      = (state_q == ST_ISSUE) && !hold;
        pos_end_s   = (s_q == steps_q);
        row_end_s   = pos_end_s && (ox_q == last_ox_s);
        last_beat_s = beat_s && row_end_s && (oy_q == last_oy_s);
        cnt_full_s  = (cnt_q == n_out_s);
        drain_to_s  = (drn_q == DRN_B'(DRAIN_MAX - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_d = cfg_bad_s ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_d = last_beat_s ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = (cnt_full_s || drain_to_s) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Config latch, window/step counters, output counter, drain timer, error flag.
    always_comb begin
        last_w_d  = last_w_q;
        last_h_d  = last_h_q;
        stride2_d = stride2_q;
        steps_d   = steps_q;
        relu_d    = relu_q;
        mp_d      = mp_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        drn_d     = drn_q;
        err_d     = err_q;
        if ((state_q == ST_IDLE) && start) begin
            last_w_d  = cfg_last_w;
            last_h_d  = cfg_last_h;
            stride2_d = cfg_stride2;
            steps_d   = cfg_steps;
            relu_d    = cfg_relu;
            mp_d      = cfg_mp;
            ox_d      = '0;
            oy_d      = '0;
            s_d       = '0;
            cnt_d     = '0;
            drn_d     = '0;
            err_d     = 1'b0;
        end else begin
            if (beat_s && !pos_end_s) begin
                s_d = s_q + STEP_B'(1);
            end else if (beat_s && !row_end_s) begin
                s_d  = '0;
                ox_d = ox_q + WIDTH_B'(1);
            end else if (beat_s) begin
                s_d  = '0;
                ox_d = '0;
                oy_d = oy_q + HEIGHT_B'(1);
            end else begin
                s_d = s_q;
            end
            // Count saturates at N; an early finish is noticed on DRAIN entry.
            if (((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && (|out_en) && !cnt_full_s) begin
                cnt_d = cnt_q + CNT_B'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (state_q == ST_DRAIN) begin
                drn_d = drn_q + DRN_B'(1);
            end else begin
                drn_d = drn_q;
            end
            if ((state_q == ST_CHECK) && cfg_bad_s) begin
                err_d = 1'b1;
            end else if ((state_q == ST_DRAIN) && !cnt_full_s && drain_to_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_w_q  <= '0;
            last_h_q  <= '0;
            stride2_q <= 1'b0;
            steps_q   <= '0;
            relu_q    <= 1'b0;
            mp_q      <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            s_q       <= '0;
            cnt_q     <= '0;
            drn_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            last_w_q  <= last_w_d;
            last_h_q  <= last_h_d;
            stride2_q <= stride2_d;
            steps_q   <= steps_d;
            relu_q    <= relu_d;
            mp_q      <= mp_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            drn_q     <= drn_d;
            err_q     <= err_d;
        end
    end

    // Output decode: a beat presents its taps the cycle after it is issued; stalls hold addresses.
    always_comb begin
        rw_d = rw_q;
        rh_d = rh_q;
        stp_d = stp_q;
        ren_d = 9'h000;
        bias_d = 1'b0;
        pe_d = 1'b0;
        if (beat_s) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    rw_d[(8 - (3 * i + j)) * WIDTH_B +: WIDTH_B]   = base_w_s + WIDTH_B'(j);
                    rh_d[(8 - (3 * i + j)) * HEIGHT_B +: HEIGHT_B] = base_h_s + HEIGHT_B'(i);
                end
            end
            ren_d  = 9'h1FF;
            bias_d = (s_q == STEP_B'(0));
            pe_d   = 1'b1;
            stp_d  = s_q;
        end else begin
            ren_d  = 9'h000;
            bias_d = 1'b0;
            pe_d   = 1'b0;
        end
        busy_d = (state_d == ST_CHECK) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q   <= '0;
            rh_q   <= '0;
            ren_q  <= 9'h000;
            bias_q <= 1'b0;
            stp_q  <= '0;
            pe_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rw_q   <= rw_d;
            rh_q   <= rh_d;
            ren_q  <= ren_d;
            bias_q <= bias_d;
            stp_q  <= stp_d;
            pe_q   <= pe_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign readi_w     = rw_q;
    assign readi_h     = rh_q;
    assign en_read     = ren_q;
    assign en_bias     = bias_q;
    assign step        = stp_q;
    assign step_p      = stp_q;
    assign en_pe       = pe_q;
    assign bound_level = steps_q;
    assign en_relu     = relu_q;
    assign en_mp       = mp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_npu_conv_seq.sv
// Bench for npu_conv_seq: a queue of expected beats built from the window loops,
// a per-cycle compare process with out_en feedback, and directed pass scenarios.
module tb_npu_conv_seq;
    logic        clk, reset, start, cfg_stride2, cfg_relu, cfg_mp, hold;
    logic [6:0]  cfg_last_w;
    logic [2:0]  cfg_last_h, cfg_steps;
    logic [7:0]  out_en;
    logic [62:0] readi_w;
    logic [26:0] readi_h;
    logic [8:0]  en_read;
    logic        en_bias, en_pe, en_relu, en_mp, busy, done, err;
    logic [2:0]  step, step_p, bound_level;

    npu_conv_seq dut (
        .clk(clk), .reset(reset), .start(start), .cfg_last_w(cfg_last_w),
        .cfg_last_h(cfg_last_h), .cfg_stride2(cfg_stride2), .cfg_steps(cfg_steps),
        .cfg_relu(cfg_relu), .cfg_mp(cfg_mp), .hold(hold), .out_en(out_en),
        .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read), .en_bias(en_bias),
        .step(step), .en_pe(en_pe), .step_p(step_p), .bound_level(bound_level),
        .en_relu(en_relu), .en_mp(en_mp), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [62:0] w;
        logic [26:0] h;
        logic [2:0]  s;
        logic        bias;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       e;
    int          total = 0, bad = 0;
    int          cyc = 0, start_cyc, done_cyc, last_beat_cyc, last_pulse_cyc;
    int          beats_seen, bias_seen, stall_cycles, done_count, pulses_left, pulses_sent;
    logic [2:0]  hist = 3'b000;
    logic [62:0] last_w_exp = '0, first_w, last_w_seen;
    logic [26:0] last_h_exp = '0, first_h, last_h_seen;
    logic [2:0]  bound_exp = 3'd0;
    logic        relu_exp = 1'b0, mp_exp = 1'b0;
    logic [62:0] lit_w;
    logic [26:0] lit_h;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Per-cycle compare against the expected beat queue, plus out_en feedback 3 cycles after each beat.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                hist   = 3'b000;
                out_en = 8'h00;
            end else begin
                if (start && !busy) start_cyc = cyc;
                if (en_pe) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", en_pe, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tap_w", readi_w, e.w);
                        chk("tap_h", readi_h, e.h);
                        chk("step", step, e.s);
                        chk("step_p", step_p, e.s);
                        chk("en_bias", en_bias, e.bias);
                        chk("en_read", en_read, 9'h1FF);
                        if (beats_seen == 0) begin
                            first_w = readi_w;
                            first_h = readi_h;
                        end
                        last_w_exp = e.w;
                        last_h_exp = e.h;
                        last_w_seen = readi_w;
                        last_h_seen = readi_h;
                        beats_seen++;
                        if (en_bias) bias_seen++;
                        last_beat_cyc = cyc;
                    end
                end else begin
                    chk("idle_en_read", en_read, 9'h000);
                    chk("idle_en_bias", en_bias, 0);
                    chk("held_w", readi_w, last_w_exp);
                    chk("held_h", readi_h, last_h_exp);
                    if (beats_seen > 0 && exp_q.size() > 0) stall_cycles++;
                end
                if (busy) begin
                    chk("bound_level", bound_level, bound_exp);
                    chk("en_relu", en_relu, relu_exp);
                    chk("en_mp", en_mp, mp_exp);
                end
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                    chk("busy_at_done", busy, 0);
                end
                if (hist[2] && pulses_left > 0) begin
                    out_en = 8'h80 >> (pulses_sent % 8);
                    pulses_sent++;
                    pulses_left--;
                    last_pulse_cyc = cyc;
                end else begin
                    out_en = 8'h00;
                end
                hist = {hist[1:0], en_pe};
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_readi_w"}, readi_w, 0);
        chk({tag, "_readi_h"}, readi_h, 0);
        chk({tag, "_en_read"}, en_read, 0);
        chk({tag, "_en_bias"}, en_bias, 0);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_en_pe"}, en_pe, 0);
        chk({tag, "_step_p"}, step_p, 0);
        chk({tag, "_bound"}, bound_level, 0);
        chk({tag, "_relu"}, en_relu, 0);
        chk({tag, "_mp"}, en_mp, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Build the expected beat list from the window loops and start a pass.
    task automatic launch(input logic [6:0] lw, input logic [2:0] lh, input logic s2,
                          input logic [2:0] st, input logic relu, input logic mp,
                          input int pulse_lim);
        int    sd, ow, oh, k;
        beat_t b;
        exp_q.delete();
        if (lw >= 7'd2 && lh >= 3'd2) begin
            sd = s2 ? 2 : 1;
            ow = (int'(lw) + 1 - 3) / sd + 1;
            oh = (int'(lh) + 1 - 3) / sd + 1;
            for (int oy = 0; oy < oh; oy++) begin
                for (int ox = 0; ox < ow; ox++) begin
                    for (int s = 0; s <= int'(st); s++) begin
                        for (int i = 0; i < 3; i++) begin
                            for (int j = 0; j < 3; j++) begin
                                k = 3 * i + j;
                                b.w[(8 - k) * 7 +: 7] = 7'(ox * sd + j);
                                b.h[(8 - k) * 3 +: 3] = 3'(oy * sd + i);
                            end
                        end
                        b.s = 3'(s);
                        b.bias = (s == 0);
                        exp_q.push_back(b);
                    end
                end
            end
        end
        beats_seen = 0; bias_seen = 0; stall_cycles = 0; done_count = 0;
        pulses_left = pulse_lim; pulses_sent = 0; hist = 3'b000;
        bound_exp = st; relu_exp = relu; mp_exp = mp;
        @(posedge clk); #1;
        cfg_last_w = lw; cfg_last_h = lh; cfg_stride2 = s2; cfg_steps = st;
        cfg_relu = relu; cfg_mp = mp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_last_w = ~lw; cfg_last_h = ~lh; cfg_stride2 = ~s2; cfg_steps = ~st;
        cfg_relu = ~relu; cfg_mp = ~mp;
        chk("err_clear", err, 0);
    endtask

    task automatic finish(input string tag, input int hold_at, input int hold_len,
                          input int restart_at, input logic exp_err, input int exp_beats);
        int waited;
        waited = 1;
        while (done_count == 0 && waited < 400) begin
            hold  = (waited >= hold_at) && (waited < hold_at + hold_len);
            start = (waited == restart_at);
            @(posedge clk); #1;
            waited++;
        end
        hold = 1'b0;
        start = 1'b0;
        if (done_count == 0) begin
            chk({tag, "_done_timeout"}, done_count, 1);
        end else begin
            repeat (2) begin
                @(posedge clk); #1;
            end
            chk({tag, "_done_once"}, done_count, 1);
            chk({tag, "_err"}, err, exp_err);
            chk({tag, "_beats"}, beats_seen, exp_beats);
            chk({tag, "_left"}, exp_q.size(), 0);
            chk({tag, "_busy_end"}, busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; out_en = 8'h00;
        cfg_last_w = 7'd0; cfg_last_h = 3'd0; cfg_stride2 = 1'b0; cfg_steps = 3'd0;
        cfg_relu = 1'b0; cfg_mp = 1'b0;
        lit_w = {7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2, 7'd0, 7'd1, 7'd2};
        lit_h = {3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;

        // 5x5, stride 1, one step per position
        launch(7'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 9);
        finish("t1", -1, 0, -1, 1'b0, 9);
        chk("t1_first_w", first_w, lit_w);
        chk("t1_first_h", first_h, lit_h);
        chk("t1_bias", bias_seen, 9);
        chk("t1_pulses", pulses_sent, 9);
        chk("t1_done_after_last_out", (done_cyc - last_pulse_cyc >= 1) && (done_cyc - last_pulse_cyc <= 3), 1);

        // 7x3, stride 2, three steps per position
        launch(7'd6, 3'd2, 1'b1, 3'd2, 1'b0, 1'b1, 9);
        finish("t2", -1, 0, -1, 1'b0, 9);
        chk("t2_bias", bias_seen, 3);
        chk("t2_last_tap0_w", last_w_seen[62:56], 4);
        chk("t2_last_tap0_h", last_h_seen[26:24], 0);
        chk("t2_bound", bound_level, 2);

        // 5x5 with a three-cycle memory stall
        launch(7'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b1, 9);
        finish("t3", 5, 3, -1, 1'b0, 9);
        chk("t3_stall", stall_cycles, 3);
        chk("t3_pulses", pulses_sent, 9);

        // illegal width
        launch(7'd1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 9);
        finish("t4", -1, 0, -1, 1'b1, 0);
        chk("t4_done_latency", done_cyc - start_cyc, 2);

        // missing last output -> drain timeout
        launch(7'd4, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 8);
        finish("t5", -1, 0, -1, 1'b1, 9);
        chk("t5_drain_len", done_cyc - last_beat_cyc, 64);
        chk("t5_pulses", pulses_sent, 8);

        // reset in the middle of ISSUE
        launch(7'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b1, 9);
        repeat (6) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_q.delete();
        last_w_exp = '0;
        last_h_exp = '0;
        #1;
        check_reset("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", done_count, 0);
        chk("abort_idle", busy, 0);

        // fresh pass with a start pulse while busy
        launch(7'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 9);
        finish("t6", -1, 0, 4, 1'b0, 9);
        chk("t6_first_w", first_w, lit_w);
        chk("t6_pulses", pulses_sent, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
